// File: rtl/pipeline_if.sv
// Instruction fetch stage with IF/ID pipeline register. Issues word fetches over a
// req/ack handshake and delivers {inst, pc, pc+4, valid} to decode.
module pipeline_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_IF,
    input  logic        rst_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_IF,
    input  logic        redirect_IF,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Inst_out_IF,
    output logic [31:0] PC_out_IF,
    output logic [31:0] PC4_out_IF,
    output logic        valid_out_IF
);
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state, state_nx;
    logic        run;
    logic [31:0] pc, pc_nx;
    logic [31:0] req_addr, req_nx;
    logic [31:0] skid_inst, skid_addr;
    logic [31:0] target, seq_addr;
    logic [31:0] ifid_inst, ifid_pc;
    logic        ack, skid_ld, ifid_ld, bubble;

    // run keeps the request low for the first cycle out of reset
    assign imem_req  = run && (state != HOLD);
    assign imem_addr = req_addr;
    assign ack       = imem_req && imem_ack;
    assign target    = {redirect_pc[31:2], 2'b00};
    assign seq_addr  = req_addr + 32'd4;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        req_nx    = req_addr;
        skid_ld   = 1'b0;
        ifid_ld   = 1'b0;
        bubble    = 1'b0;
        ifid_inst = imem_rdata;
        ifid_pc   = req_addr;
        if (redirect_IF) begin
            // Flush beats stall; an unacked request must finish at its old address first
            bubble = 1'b1;
            pc_nx  = target;
            case (state)
                FETCH: begin
                    if (ack || !run) req_nx = target;
                    else             state_nx = DRAIN;
                end
                DRAIN: begin
                    if (ack) begin
                        req_nx   = target;
                        state_nx = FETCH;
                    end
                end
                default: begin
                    req_nx   = target;
                    state_nx = FETCH;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        pc_nx = seq_addr;
                        if (stall_IF) begin
                            skid_ld  = 1'b1;
                            state_nx = HOLD;
                        end else begin
                            ifid_ld = 1'b1;
                            req_nx  = seq_addr;
                        end
                    end else if (!stall_IF) begin
                        bubble = 1'b1;
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        req_nx   = pc;
                        state_nx = FETCH;
                    end
                end
                default: begin
                    if (!stall_IF) begin
                        ifid_ld   = 1'b1;
                        ifid_inst = skid_inst;
                        ifid_pc   = skid_addr;
                        req_nx    = pc;
                        state_nx  = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_IF or negedge rst_IF) begin
        if (!rst_IF) begin
            state        <= FETCH;
            run          <= 1'b0;
            pc           <= RESET_PC;
            req_addr     <= RESET_PC;
            skid_inst    <= 32'd0;
            skid_addr    <= 32'd0;
            Inst_out_IF  <= NOP_INST;
            PC_out_IF    <= 32'd0;
            PC4_out_IF   <= 32'd4;
            valid_out_IF <= 1'b0;
        end else begin
            run      <= 1'b1;
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_nx;
            if (skid_ld) begin
                skid_inst <= imem_rdata;
                skid_addr <= req_addr;
            end
            // A bubble keeps the last PC so only inst/valid change
            if (bubble) begin
                Inst_out_IF  <= NOP_INST;
                valid_out_IF <= 1'b0;
            end else if (ifid_ld) begin
                Inst_out_IF  <= ifid_inst;
                PC_out_IF    <= ifid_pc;
                PC4_out_IF   <= ifid_pc + 32'd4;
                valid_out_IF <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_if.sv
// Bench for pipeline_if: directed scenarios with literal expectations, then random
// memory latency / stall / redirect traffic checked against an instruction-stream model.
module tb_pipeline_if;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_IF = 1'b0;
    logic        rst_IF = 1'b1;
    logic        imem_ack, stall_IF, redirect_IF;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, valid;
    logic [31:0] imem_addr, inst, pc, pc4;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_pc, w_pc4, w_rdata;

    int total = 0;
    int bad   = 0;
    int n_deliv = 0;

    always #5 clk_IF = ~clk_IF;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign w_rdata = rom(w_addr);

    pipeline_if dut (
        .clk_IF(clk_IF), .rst_IF(rst_IF),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_IF(stall_IF), .redirect_IF(redirect_IF), .redirect_pc(redirect_pc),
        .Inst_out_IF(inst), .PC_out_IF(pc), .PC4_out_IF(pc4), .valid_out_IF(valid)
    );

    pipeline_if #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_IF(clk_IF), .rst_IF(rst_IF),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_rdata(w_rdata),
        .stall_IF(1'b0), .redirect_IF(1'b0), .redirect_pc(32'd0),
        .Inst_out_IF(w_inst), .PC_out_IF(w_pc), .PC4_out_IF(w_pc4), .valid_out_IF(w_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge
    logic        ap_stall, ap_redir, ap_ack;
    logic [31:0] ap_tgt;
    always @(posedge clk_IF) begin
        ap_stall <= stall_IF;
        ap_redir <= redirect_IF;
        ap_tgt   <= redirect_pc;
        ap_ack   <= imem_ack;
    end

    // Instruction-stream model: next real instruction must be exp_pc
    logic [31:0] exp_pc, prev_inst, prev_pc, prev_pc4, prev_addr;
    logic        prev_valid, prev_req;
    always @(negedge clk_IF) begin
        if (!rst_IF) begin
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_inst", inst, NOP);
            chk("rst_pc", pc, 32'd0);
            chk("rst_pc4", pc4, 32'd4);
            chk("rst_req", 32'(imem_req), 32'd0);
            exp_pc = 32'd0;
        end else begin
            if (ap_redir) begin
                chk("flush_valid", 32'(valid), 32'd0);
                exp_pc = ap_tgt & 32'hFFFF_FFFC;
            end else if (ap_stall) begin
                chk("stall_inst", inst, prev_inst);
                chk("stall_pc", pc, prev_pc);
                chk("stall_pc4", pc4, prev_pc4);
                chk("stall_valid", 32'(valid), 32'(prev_valid));
            end else if (valid) begin
                chk("seq_pc", pc, exp_pc);
                chk("seq_inst", inst, rom(exp_pc));
                chk("seq_pc4", pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end else begin
                chk("bubble_pc", pc, prev_pc);
            end
            if (prev_req && !ap_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
        end
        chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (!valid) chk("bubble_nop", inst, NOP);
        prev_inst  = inst;
        prev_pc    = pc;
        prev_pc4   = pc4;
        prev_valid = valid;
        prev_req   = imem_req;
        prev_addr  = imem_addr;
    end

    // Memory responder and stimulus
    bit          busy = 1'b0;
    int          wl = 0;
    int          wait_lo = 0, wait_hi = 0;
    logic        stall_v = 1'b0, redir_v = 1'b0;
    logic [31:0] tgt_v = 32'd0;

    task automatic step();
        if (imem_req) begin
            if (!busy) begin
                busy = 1'b1;
                wl = int'($urandom_range(wait_hi, wait_lo));
            end
            imem_ack   = (wl == 0);
            imem_rdata = imem_ack ? rom(imem_addr) : $urandom();
            if (wl == 0) busy = 1'b0;
            else         wl--;
        end else begin
            busy       = 1'b0;
            imem_ack   = 1'($urandom_range(1, 0));
            imem_rdata = $urandom();
        end
        stall_IF    = stall_v;
        redirect_IF = redir_v;
        redirect_pc = tgt_v;
        @(negedge clk_IF);
        #1;
    endtask

    task automatic do_reset();
        rst_IF  = 1'b0;
        stall_v = 1'b0;
        redir_v = 1'b0;
        #1;
        chk("async_rst_req", 32'(imem_req), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_inst", inst, 32'h0000_0013);
        chk("async_rst_pc4", pc4, 32'h0000_0004);
        step();
        step();
        rst_IF = 1'b1;
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = 32'd0;
        stall_IF = 1'b0; redirect_IF = 1'b0; redirect_pc = 32'd0;
        #1;
        // Zero-wait streaming, plus the wrapping instance
        do_reset();
        chk("w_rst_pc", w_pc, 32'h0);
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", 32'(valid), 32'd0);
        chk("w_first_addr", w_addr, 32'hFFFF_FFF8);
        step();
        chk("z_pc0", pc, 32'h0);
        chk("z_inst0", inst, 32'h5A5A_5A5A);
        chk("z_valid0", 32'(valid), 32'd1);
        chk("w_pc0", w_pc, 32'hFFFF_FFF8);
        step();
        chk("z_pc4", pc, 32'h4);
        chk("w_pc1", w_pc, 32'hFFFF_FFFC);
        chk("w_pc4_wrap", w_pc4, 32'h0);
        step();
        chk("z_pc8", pc, 32'h8);
        chk("w_pc2", w_pc, 32'h0);
        chk("w_pc2_4", w_pc4, 32'h4);
        chk("w_valid2", 32'(w_valid), 32'd1);
        step();
        chk("z_pc12", pc, 32'hC);
        chk("z_inst12", inst, rom(32'hC));

        // Two wait cycles per fetch
        do_reset();
        wait_lo = 2; wait_hi = 2;
        step();
        chk("w2_addr_e1", imem_addr, 32'h0);
        step();
        chk("w2_addr_e2", imem_addr, 32'h0);
        chk("w2_bub_e2", 32'(valid), 32'd0);
        step();
        chk("w2_addr_e3", imem_addr, 32'h0);
        chk("w2_inst_e3", inst, 32'h0000_0013);
        step();
        chk("w2_pc_e4", pc, 32'h0);
        chk("w2_valid_e4", 32'(valid), 32'd1);
        chk("w2_addr_e4", imem_addr, 32'h4);
        step();
        chk("w2_bub_e5", 32'(valid), 32'd0);
        step();
        chk("w2_bub_e6", 32'(valid), 32'd0);
        step();
        chk("w2_pc_e7", pc, 32'h4);
        chk("w2_valid_e7", 32'(valid), 32'd1);

        // Stall while PC 8 is acked -> skid, HOLD, replay
        do_reset();
        wait_lo = 0; wait_hi = 0;
        step(); step(); step();
        chk("st_pc_e3", pc, 32'h4);
        stall_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_pc", pc, 32'h4);
            chk("st_hold_req", 32'(imem_req), 32'd0);
        end
        stall_v = 1'b0;
        step();
        chk("st_pc8", pc, 32'h8);
        chk("st_inst8", inst, rom(32'h8));
        chk("st_addr12", imem_addr, 32'hC);
        step();
        chk("st_pc12", pc, 32'hC);

        // Redirect during a 3-wait request
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("rd_addr10", imem_addr, 32'h10);
        wait_lo = 3; wait_hi = 3;
        redir_v = 1'b1; tgt_v = 32'h103;
        step();
        redir_v = 1'b0; wait_lo = 0; wait_hi = 0;
        chk("rd_bubble", 32'(valid), 32'd0);
        chk("rd_drain_addr6", imem_addr, 32'h10);
        step();
        chk("rd_drain_addr7", imem_addr, 32'h10);
        step();
        chk("rd_drain_addr8", imem_addr, 32'h10);
        step();
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_valid9", 32'(valid), 32'd0);
        step();
        chk("rd_pc", pc, 32'h100);
        chk("rd_valid", 32'(valid), 32'd1);

        // Redirect and stall together
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("rs_pc20", pc, 32'h20);
        stall_v = 1'b1; redir_v = 1'b1; tgt_v = 32'h40;
        step();
        chk("rs_flush", 32'(valid), 32'd0);
        stall_v = 1'b0; redir_v = 1'b0;
        step();
        chk("rs_pc40", pc, 32'h40);
        chk("rs_valid", 32'(valid), 32'd1);

        // Random traffic
        do_reset();
        n_deliv = 0;
        wait_lo = 0; wait_hi = 3;
        for (int i = 0; i < 4000; i++) begin
            stall_v = ($urandom_range(99, 0) < 30);
            redir_v = ($urandom_range(99, 0) < 8);
            tgt_v   = $urandom_range(1023, 0);
            if ($urandom_range(499, 0) == 0) do_reset();
            step();
        end
        chk("progress", 32'(n_deliv > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_if.md
Name: pipeline_if

Overview:
- Instruction-fetch stage and IF/ID pipeline register; the producer end of the decode stage's instruction interface.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Delivers the instruction, its PC and a valid flag to ID.
- Honours ID stall, and EX redirect/flush for taken branches and jumps.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID for a bubble

Ports:
clk_IF  in  1  clock, rising edge
rst_IF  in  1  asynchronous reset, active-low
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address; stable while imem_req=1 and ack not yet seen
imem_ack  in  1  data valid this cycle; may arrive the same cycle as req or after N wait cycles
imem_rdata  in  32  instruction word, sampled only when imem_req & imem_ack
stall_IF  in  1  ID cannot accept; IF/ID contents must hold
redirect_IF  in  1  taken branch/jump from EX
redirect_pc  in  32  target; bits [1:0] forced to 0
Inst_out_IF  out  32  IF/ID instruction
PC_out_IF  out  32  IF/ID instruction address
PC4_out_IF  out  32  PC_out_IF + 4, modulo 2^32
valid_out_IF  out  1  IF/ID holds a real instruction

Behaviour:
- Reset, rst_IF=0, asynchronous:
  - Internal state: pc=RESET_PC, req_addr=RESET_PC, state=FETCH, skid buffer empty.
  - Outputs: Inst_out_IF=NOP_INST, PC_out_IF=0, PC4_out_IF=4, valid_out_IF=0, imem_req=0.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Registers: pc (next fetch address), req_addr (address driving imem_addr), skid {inst, addr}, 2-bit state.
- FETCH (imem_req=1, imem_addr=req_addr):
  - ack & !stall & !redirect:
    - IF/ID <= {imem_rdata, req_addr, valid=1}.
    - req_addr <= req_addr+4 and pc <= req_addr+4.
    - Stay in FETCH. Back-to-back zero-wait fetch gives 1 instruction per cycle.
  - ack & stall & !redirect:
    - IF/ID holds.
    - skid <= {imem_rdata, req_addr}.
    - pc <= req_addr+4.
    - Go to HOLD.
  - !ack & !stall & !redirect: IF/ID <= bubble (NOP_INST, valid=0, PC unchanged); stay in FETCH.
  - !ack & stall & !redirect: IF/ID holds; stay in FETCH.
  - redirect & ack: data discarded; req_addr <= pc <= redirect_pc; stay in FETCH.
  - redirect & !ack: pc <= redirect_pc; req_addr unchanged; go to DRAIN.
- DRAIN (imem_req=1, imem_addr=old req_addr):
  - Wait for ack; the returned data is discarded.
  - On ack: req_addr <= pc; go to FETCH.
  - A further redirect in DRAIN overwrites pc; the newest target wins.
- HOLD (imem_req=0):
  - While stall: IF/ID and skid hold.
  - When !stall: IF/ID <= {skid.inst, skid.addr, 1}; req_addr <= pc; go to FETCH.
  - Redirect in HOLD: skid discarded; req_addr <= pc <= redirect_pc; go to FETCH.
- Redirect, any state:
  - Same edge: IF/ID <= bubble (valid=0, NOP_INST). This overrides stall_IF, since the flush wins over the stall.
  - No instruction fetched before the redirect reaches ID afterwards.
- Protocol invariant: once imem_req rises, imem_req and imem_addr stay constant until ack is seen. Redirect never changes imem_addr mid-request; DRAIN handles this.
- Arithmetic: all +4 is 32-bit and wraps (0xFFFF_FFFC -> 0x0000_0000). PC4_out_IF is registered together with PC_out_IF.
- No instruction is ever lost or duplicated except the ones a redirect deliberately discards.
- Reset asserted mid-request: everything returns to reset values immediately. The stale ack that follows is ignored, because imem_req=0 in the reset cycle.
- Verification assertions:
  - imem_addr[1:0] == 0 at all times.
  - valid_out_IF == 0 implies Inst_out_IF == NOP_INST.

Test Plan:
- Reset with ack tied high, stall=0 -> valid 1 from the 2nd edge after release; PC_out_IF sequence 0, 4, 8, 12 on consecutive cycles with Inst matching the ROM.
- ack delayed 2 cycles per fetch -> imem_addr held constant 3 cycles; two bubbles (valid 0, Inst 0x00000013) between instructions at PC 0 and 4.
- stall_IF=1 for 3 cycles while the fetch of PC 8 is acked -> IF/ID holds PC 4; imem_req low during HOLD; after release PC 8 then 12 appear, none skipped.
- redirect_IF=1, redirect_pc=0x103 while a 3-wait-cycle request for 0x10 is outstanding -> imem_addr stays 0x10 until ack; data discarded; next request 0x100; IF/ID bubble; next valid PC_out_IF=0x100.
- redirect and stall asserted in the same cycle with IF/ID holding PC 0x20 -> valid_out_IF=0 the next cycle; next valid PC is the redirect target.
- RESET_PC=32'hFFFF_FFF8 with zero-wait memory -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PC4_out_IF=0 at FFFF_FFFC.
